// File: rtl/alu_multiplier_if.sv
// ============================================================================
//  Module      : alu_multiplier_if
//  Description : Request/result bundle between a requester (control unit,
//                result mux) and the iterative multiplier.
//                  Start     : request, honoured only while Busy is low
//                  A, B      : multiplicand / multiplier, captured with Start
//                  Busy      : multiplier is iterating
//                  Done      : one-cycle pulse, result valid in that cycle
//                  Product   : low half of the product (ALU MUL input)
//                  ProductHi : high half of the product
//  Modports    : master (requester side), slave (multiplier side)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_multiplier_if #(
    parameter int WIDTH = 24
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Product;
    logic [WIDTH-1:0] ProductHi;

    modport master (
        output Start, A, B,
        input  Busy, Done, Product, ProductHi
    );

    modport slave (
        input  Start, A, B,
        output Busy, Done, Product, ProductHi
    );
endinterface

`default_nettype wire

// File: rtl/alu_multiplier.sv
// ============================================================================
//  Module      : alu_multiplier
//  Description : Iterative unsigned shift-add multiplier, one multiplier bit
//                per clock. The full 2*WIDTH-bit product is accumulated in P;
//                the low half drives Product, the high half ProductHi.
//  Ports       : Clock   - rising-edge clock
//                Reset_n - asynchronous active-low reset
//                bus     - alu_multiplier_if.slave (Start/A/B in,
//                          Busy/Done/Product/ProductHi out)
//  Options     : MUL_EARLY_EXIT_EN - when defined, RUN terminates as soon as
//                the remaining multiplier bits are all zero (variable
//                latency, identical results).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_multiplier #(
    parameter int WIDTH = 24
) (
    input  wire logic       Clock,
    input  wire logic       Reset_n,
    alu_multiplier_if.slave bus
);

    localparam int             CW         = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0]  C_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_p;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    logic               w_carry;
    logic [WIDTH-1:0]   w_sum;
    logic [2*WIDTH-1:0] w_p_step;
    logic [2*WIDTH-1:0] w_p_next;
    logic               w_last;

    // Conditional add of the multiplicand into the upper half; the carry out
    // becomes the new MSB after the shift so nothing is ever truncated.
    always_comb begin
        if (r_p[0]) begin
            {w_carry, w_sum} = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        end else begin
            w_carry = 1'b0;
            w_sum   = r_p[2*WIDTH-1:WIDTH];
        end
    end

    assign w_p_step = {w_carry, w_sum, r_p[WIDTH-1:1]};

`ifdef MUL_EARLY_EXIT_EN
    // After this step, P[cnt-2:0] still holds unconsumed multiplier bits.
    // If they are all zero, the remaining iterations would only shift, so
    // the whole remaining shift is applied at once.
    logic [WIDTH-1:0] w_rem_mask;
    logic             w_rem_zero;

    always_comb begin
        w_rem_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rem_mask[i] = ((32'(i) + 32'd1) < 32'(r_cnt));
        end
    end

    assign w_rem_zero = ((w_p_step[WIDTH-1:0] & w_rem_mask) == '0);
    assign w_last     = (r_cnt == C_CNT_ONE) || w_rem_zero;
    assign w_p_next   = w_p_step >> (r_cnt - C_CNT_ONE);
`else
    assign w_last     = (r_cnt == C_CNT_ONE);
    assign w_p_next   = w_p_step;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_mcand <= '0;
            r_p     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (bus.Start) begin
                        r_mcand <= bus.A;
                        r_p     <= {{WIDTH{1'b0}}, bus.B};
                        r_cnt   <= C_CNT_LOAD;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_p <= w_p_next;
                    if (w_last) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt - C_CNT_ONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Product   = r_p[WIDTH-1:0];
    assign bus.ProductHi = r_p[2*WIDTH-1:WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_alu_multiplier.sv
// ============================================================================
//  Module      : tb_alu_multiplier
//  Description : Self-checking bench for alu_multiplier. Expected products
//                come from plain 64-bit multiplication; expected latency from
//                the operand width (or the multiplier MSB when early exit
//                is enabled).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_multiplier;

    localparam int W = 24;

    logic Clock = 1'b0;
    logic Reset_n;

    alu_multiplier_if #(.WIDTH(W)) bus ();

    alu_multiplier #(.WIDTH(W)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Edges from the Start edge until Done is sampled high.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
        int m;
        m = 0;
        for (int i = 0; i < W; i++) if (b[i]) m = i + 1;
        if (m < 1) m = 1;
        return m + 1;
`else
        return W + 1;
`endif
    endfunction

    // Present a request for one edge, then scramble the operand lines so any
    // late re-sampling corrupts the result.
    task automatic kick(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.Start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
    endtask

    // Called 1 time unit after the Start edge; returns at Done-visible time.
    task automatic wait_done(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [63:0] prod;
        int lat, k, bc;
        prod = 64'(a) * 64'(b);
        lat  = exp_lat(b);
        k    = 0;
        bc   = (bus.Busy === 1'b1) ? 1 : 0;
        while (bus.Done !== 1'b1 && k < 100) begin
            @(posedge Clock); #1;
            k++;
            if (bus.Busy === 1'b1) bc++;
        end
        check({tag, "_done"},  64'(bus.Done), 64'd1);
        check({tag, "_lat"},   64'(k + 1), 64'(lat));
        check({tag, "_busyn"}, 64'(bc), 64'(lat - 1));
        check({tag, "_lo"},    64'(bus.Product),   64'(prod[W-1:0]));
        check({tag, "_hi"},    64'(bus.ProductHi), 64'(prod[2*W-1:W]));
        check({tag, "_busy0"}, 64'(bus.Busy), 64'd0);
    endtask

    // One idle cycle after Done: pulse ends, result holds.
    task automatic settle(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [63:0] prod;
        prod = 64'(a) * 64'(b);
        @(posedge Clock); #1;
        check({tag, "_donepulse"}, 64'(bus.Done), 64'd0);
        check({tag, "_hold"}, {bus.ProductHi, bus.Product}, 64'(prod[2*W-1:0]));
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        kick(a, b);
        wait_done(a, b, tag);
        settle(a, b, tag);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int dn;

        // Reset state
        Reset_n   = 1'b0;
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", 64'(bus.Busy), 64'd0);
        check("rst_done", 64'(bus.Done), 64'd0);
        check("rst_lo",   64'(bus.Product), 64'd0);
        check("rst_hi",   64'(bus.ProductHi), 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock); #1;

        // Basic and maximum operands
        op(24'd3, 24'd5, "basic");
        op(24'hFFFFFF, 24'hFFFFFF, "max");
        check("max_hi_const", 64'(bus.ProductHi), 64'hFFFFFE);
        check("max_lo_const", 64'(bus.Product), 64'h000001);

        // Start while busy is ignored
        kick(24'd2, 24'd2);
        dn = 0;
        for (int c = 0; c < 60; c++) begin
            if (c == 5) begin
                bus.Start = 1'b1;
                bus.A     = 24'd7;
                bus.B     = 24'd7;
            end
            @(posedge Clock); #1;
            bus.Start = 1'b0;
            if (bus.Done === 1'b1) dn++;
        end
        check("busy_ign_ndone", 64'(dn), 64'd1);
        check("busy_ign_lo", 64'(bus.Product), 64'd4);
        check("busy_ign_hi", 64'(bus.ProductHi), 64'd0);

        // Asynchronous reset mid-operation
        kick(24'h000123, 24'hFFF456);
        repeat (10) @(posedge Clock);
        #3;
        Reset_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.Busy), 64'd0);
        check("midrst_done", 64'(bus.Done), 64'd0);
        check("midrst_lo",   64'(bus.Product), 64'd0);
        check("midrst_hi",   64'(bus.ProductHi), 64'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge Clock); #1;
            if (bus.Done === 1'b1) dn++;
        end
        check("midrst_nodone", 64'(dn), 64'd0);
        op(24'd6, 24'd7, "after_rst");

        // Back-to-back: new Start in the DONE cycle
        kick(24'h55, 24'd3);
        wait_done(24'h55, 24'd3, "b2b_first");
        bus.Start = 1'b1;
        bus.A     = 24'h000100;
        bus.B     = 24'h000100;
        #1;
        check("b2b_hold", 64'(bus.Product), 64'hFF);
        @(posedge Clock); #1;
        bus.Start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        check("b2b_restart_busy", 64'(bus.Busy), 64'd1);
        check("b2b_restart_done", 64'(bus.Done), 64'd0);
        wait_done(24'h000100, 24'h000100, "b2b_second");
        settle(24'h000100, 24'h000100, "b2b_second");

        // Early-exit boundary operands (fixed latency without the option)
        op(24'h123456, 24'd1, "b_one");
        op(24'h123456, 24'd0, "b_zero");
        op(24'd0, 24'hABCDEF, "a_zero");
        op(24'hFFFFFF, 24'h800000, "b_msb");

        // Randomized operands against the arithmetic model
        for (int n = 0; n < 16; n++) begin
            ra = W'($urandom);
            rb = W'($urandom) >> $urandom_range(0, W - 1);
            op(ra, rb, $sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
